// File: rtl/load_store_unit.sv
// load_store_unit: sequences execute-stage load/store requests onto the
// data_memory port (addr, shared tri-state bus, re/we, access size) and
// returns one response per request to writeback.
// Size encoding: BYTE_S=0, BYTE_U=1, HALF_S=2, HALF_U=3, WORD=4.
// Optional feature: define MISALIGN_SPLIT_EN to break misaligned HALF/WORD
// accesses into byte beats instead of rejecting them with an error.
module load_store_unit #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [2:0]    req_size_i,
    input  logic [31:0]   req_wdata_i,
    output logic          resp_valid_o,
    input  logic          resp_ready_i,
    output logic [31:0]   resp_rdata_o,
    output logic          resp_err_o,
    output logic [AW-1:0] mem_addr_o,
    inout  wire  [31:0]   mem_bus_io,
    output logic          mem_re_o,
    output logic          mem_we_o,
    output logic [2:0]    mem_size_o
);

    localparam logic [2:0] SZ_BYTE_S = 3'd0;
    localparam logic [2:0] SZ_BYTE_U = 3'd1;
    localparam logic [2:0] SZ_HALF_S = 3'd2;
    localparam logic [2:0] SZ_HALF_U = 3'd3;
    localparam logic [2:0] SZ_WORD   = 3'd4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
`ifdef MISALIGN_SPLIT_EN
    localparam logic [1:0] SPLIT  = 2'd2;
`endif
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    size_q, size_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
`ifdef MISALIGN_SPLIT_EN
    logic [1:0]    beat_q, beat_d;
    logic [1:0]    last_beat;
`endif
    logic          misaligned;
    logic [2:0]    store_size;
    logic [31:0]   bus_out;

    // Halfwords need an even address, words a 4-byte aligned one.
    always_comb begin
        misaligned = ((req_size_i == SZ_HALF_S || req_size_i == SZ_HALF_U) && req_addr_i[0]) ||
                     (req_size_i == SZ_WORD && req_addr_i[1:0] != 2'b00);
    end

    // Memory ignores sign on writes, so stores always present the unsigned size.
    always_comb begin
        store_size = size_q;
        if (size_q == SZ_BYTE_S) store_size = SZ_BYTE_U;
        if (size_q == SZ_HALF_S) store_size = SZ_HALF_U;
    end

    // Next-state and request/response datapath.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef MISALIGN_SPLIT_EN
        beat_d    = beat_q;
        last_beat = (size_q == SZ_WORD) ? 2'd3 : 2'd1;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    size_d  = req_size_i;
                    wdata_d = req_wdata_i;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
`ifdef MISALIGN_SPLIT_EN
                    beat_d  = 2'd0;
                    state_d = misaligned ? SPLIT : ACCESS;
`else
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ACCESS;
                    end
`endif
                end
            end
            ACCESS: begin
                if (!we_q) rdata_d = mem_bus_io;
                state_d = RESP;
            end
`ifdef MISALIGN_SPLIT_EN
            SPLIT: begin
                if (!we_q) rdata_d[{beat_q, 3'b000} +: 8] = mem_bus_io[7:0];
                beat_d = beat_q + 2'd1;
                if (beat_q == last_beat) begin
                    // Upper bits are already zero from the accept; only HALF_S needs filling.
                    if (!we_q && size_q == SZ_HALF_S) rdata_d[31:16] = {16{rdata_d[15]}};
                    state_d = RESP;
                end
            end
`endif
            RESP: begin
                if (resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched request; reset drops everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= SZ_WORD;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            beat_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef MISALIGN_SPLIT_EN
            beat_q  <= beat_d;
`endif
        end
    end

    // Memory port is decoded from state so it idles the moment reset hits.
    always_comb begin
        mem_re_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_size_o = SZ_WORD;
        bus_out    = 32'd0;
        case (state_q)
            ACCESS: begin
                mem_re_o   = !we_q;
                mem_we_o   = we_q;
                mem_addr_o = addr_q;
                mem_size_o = we_q ? store_size : size_q;
                bus_out    = wdata_q;
            end
`ifdef MISALIGN_SPLIT_EN
            SPLIT: begin
                mem_re_o   = !we_q;
                mem_we_o   = we_q;
                mem_addr_o = addr_q + AW'(beat_q);
                mem_size_o = SZ_BYTE_U;
                bus_out    = {24'd0, wdata_q[{beat_q, 3'b000} +: 8]};
            end
`endif
            default: ;
        endcase
    end

    assign mem_bus_io   = mem_we_o ? bus_out : 32'bz;
    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule
